// File: rtl/prbs5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs5_pkg
// Brief    : Shared types and constants for the serial PRBS-5 checker.
// Revision : 1.0
// ============================================================================
package prbs5_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PRBS_LEN = 5;
  localparam int TAP_A    = 4;
  localparam int TAP_B    = 2;
  localparam int PERIOD   = 31;

  // Next expected bit from the last five received (hist[0] newest).
  function automatic logic prbs5_pred(input logic [PRBS_LEN-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs5_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear (clear has priority).
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prbs5_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs5_checker
// Brief    : Self-synchronising serial PRBS-5 checker with lock FSM and
//            saturating error counter. Define PRBS5_CHK_BITCNT_EN to add the
//            bit_count output (bits sampled while locked).
// Revision : 1.0
// ============================================================================
module prbs5_checker
  import prbs5_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
`ifdef PRBS5_CHK_BITCNT_EN
  output logic [CNT_W-1:0] bit_count,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);
  localparam int FILL_W = $clog2(PRBS_LEN + 1);

  localparam logic [GOOD_W-1:0] c_lock_last = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  c_loss_last = BAD_W'(LOSS_CNT - 1);
  localparam logic [FILL_W-1:0] c_fill_last = FILL_W'(PRBS_LEN - 1);

  state_t              r_state, w_state_nxt;
  logic [PRBS_LEN-1:0] r_hist, w_hist_nxt;
  logic [FILL_W-1:0]   r_fill, w_fill_nxt;
  logic [GOOD_W-1:0]   r_good, w_good_nxt;
  logic [BAD_W-1:0]    r_bad, w_bad_nxt;
  logic                r_locked, r_err_pulse;
  logic                w_pred, w_match, w_err;

  assign w_pred  = prbs5_pred(r_hist);
  assign w_match = (bit_in == w_pred);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_hist      <= '0;
      r_fill      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hist      <= w_hist_nxt;
      r_fill      <= w_fill_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_err_pulse <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_err       = 1'b0;
    if (bit_valid) begin
      unique case (r_state)
        HUNT: begin
          w_hist_nxt = {r_hist[PRBS_LEN-2:0], bit_in};
          w_fill_nxt = r_fill + 1'b1;
          if (r_fill == c_fill_last) begin
            w_state_nxt = VERIFY;
            w_good_nxt  = '0;
          end
        end
        VERIFY: begin
          w_hist_nxt = {r_hist[PRBS_LEN-2:0], bit_in};
          // An all-zero history predicts zeros forever; never count it as sync.
          if ((r_hist == '0) || !w_match) begin
            w_good_nxt = '0;
          end else begin
            w_good_nxt = r_good + 1'b1;
            if (r_good == c_lock_last) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
            end
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one channel error is counted once.
          w_hist_nxt = {r_hist[PRBS_LEN-2:0], w_pred};
          if (w_match) begin
            w_bad_nxt = '0;
          end else begin
            w_err     = 1'b1;
            w_bad_nxt = r_bad + 1'b1;
            if (r_bad == c_loss_last) begin
              w_state_nxt = HUNT;
              w_fill_nxt  = '0;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err),
    .clr   (clr_count),
    .q     (err_count)
  );

`ifdef PRBS5_CHK_BITCNT_EN
  logic w_bit_inc;
  assign w_bit_inc = bit_valid && (r_state == LOCKED);

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bit_inc),
    .clr   (clr_count),
    .q     (bit_count)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs5_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs5_checker
// Brief    : Randomised self-checking bench for prbs5_checker against a
//            queue-based behavioural model of the lock/error rules.
// Revision : 1.0
// ============================================================================
module tb_prbs5_checker;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             clr_count = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
`ifdef PRBS5_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  prbs5_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_count (clr_count),
    .locked    (locked),
    .err_pulse (err_pulse),
`ifdef PRBS5_CHK_BITCNT_EN
    .bit_count (bit_count),
`endif
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Generator sequence from the recurrence b(n+5) = b(n) ^ b(n+2).
  bit seq [31];
  int gpos = 0;

  function automatic bit gen_bit();
    bit b;
    b    = seq[gpos];
    gpos = (gpos + 1) % 31;
    return b;
  endfunction

  // Behavioural model: mode 0 hunting, 1 verifying, 2 locked.
  int m_mode, m_fill, m_good, m_bad, m_cnt, m_bits;
  bit m_locked, m_pulse;
  bit m_h[$];

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_bits = 0;
    m_locked = 0; m_pulse = 0;
    m_h = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p;
    bit zero;
    m_pulse = 0;
    if (v) begin
      p    = m_h[0] ^ m_h[2];
      zero = (m_h[0] | m_h[1] | m_h[2] | m_h[3] | m_h[4]) == 1'b0;
      if (m_mode == 2 && m_bits < CNT_MAX) m_bits++;
      case (m_mode)
        0: begin
          m_h.push_back(b); void'(m_h.pop_front());
          m_fill++;
          if (m_fill == 5) begin m_mode = 1; m_good = 0; end
        end
        1: begin
          m_h.push_back(b); void'(m_h.pop_front());
          if (zero || b != p) m_good = 0;
          else begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
          end
        end
        default: begin
          m_h.push_back(p); void'(m_h.pop_front());
          if (b == p) m_bad = 0;
          else begin
            m_pulse = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            m_bad++;
            if (m_bad == LOSS_CNT) begin m_mode = 0; m_fill = 0; end
          end
        end
      endcase
    end
    if (c) begin m_cnt = 0; m_bits = 0; end
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    bit_valid = v; bit_in = b; clr_count = c;
    @(posedge clk);
    model_step(v, b, c);
    #1;
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
    check("err_count", 32'(err_count), 32'(m_cnt));
`ifdef PRBS5_CHK_BITCNT_EN
    check("bit_count", 32'(bit_count), 32'(m_bits));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bit_valid = 1'b0; clr_count = 1'b0;
    #1;
    model_reset();
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_pulse", {31'd0, err_pulse}, 32'd0);
    check("arst_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, gen_bit(), 1'b0);
  endtask

  initial begin
    int nv;
    int src;
    seq[0] = 1; seq[1] = 0; seq[2] = 0; seq[3] = 1; seq[4] = 0;
    for (int n = 5; n < 31; n++) seq[n] = seq[n-5] ^ seq[n-3];
    model_reset();

    // Clean lock after 13 bits, then a long clean run.
    do_reset();
    clean(12);
    check("lock_at12", {31'd0, locked}, 32'd0);
    clean(1);
    check("lock_at13", {31'd0, locked}, 32'd1);
    clean(1000);
    check("clean_count", 32'(err_count), 32'd0);

    // Single flipped bit counted once.
    step(1'b1, ~gen_bit(), 1'b0);
    check("flip1_pulse", {31'd0, err_pulse}, 32'd1);
    clean(20);
    check("flip1_count", 32'(err_count), 32'd1);
    check("flip1_locked", {31'd0, locked}, 32'd1);

    // Loss of lock after four consecutive errors, then relock.
    step(1'b1, gen_bit(), 1'b1);
    check("clr_count", 32'(err_count), 32'd0);
    for (int i = 0; i < LOSS_CNT; i++) step(1'b1, ~gen_bit(), 1'b0);
    check("loss_count", 32'(err_count), 32'd4);
    check("loss_locked", {31'd0, locked}, 32'd0);
    clean(12);
    check("relock_at12", {31'd0, locked}, 32'd0);
    clean(1);
    check("relock_at13", {31'd0, locked}, 32'd1);

    // All-zero stream never locks.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    check("zero_locked", {31'd0, locked}, 32'd0);
    check("zero_count", 32'(err_count), 32'd0);

    // Alternating bit_valid.
    do_reset();
    gpos = 0;
    nv = 0;
    while (nv < 13) begin
      step(1'b1, gen_bit(), 1'b0); nv++;
      if (nv < 13) step(1'b0, 1'b0, 1'b0);
    end
    check("gap_lock", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i == 10) ? ~gen_bit() : gen_bit(), 1'b0);
      step(1'b0, 1'b1, 1'b0);
      if (i == 10) check("gap_nopulse", {31'd0, err_pulse}, 32'd0);
    end

    // Clear wins over simultaneous error; async reset while locked.
    step(1'b1, ~gen_bit(), 1'b1);
    check("clr_wins", 32'(err_count), 32'd0);
    check("clr_pulse", {31'd0, err_pulse}, 32'd1);
    clean(3);
    do_reset();

    // Saturation of the error counter.
    gpos = 0;
    clean(13);
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      clean(10);
      step(1'b1, ~gen_bit(), 1'b0);
    end
    check("sat_count", 32'(err_count), 32'(CNT_MAX));
    check("sat_pulse", {31'd0, err_pulse}, 32'd1);
    check("sat_locked", {31'd0, locked}, 32'd1);

    // Randomised traffic.
    src = 2;
    for (int i = 0; i < 4000; i++) begin
      bit v, b, c;
      if (i % 200 == 0) src = $urandom_range(0, 5);
      if ($urandom_range(0, 599) == 0) do_reset();
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      case (src)
        0:       b = 1'($urandom_range(0, 1));
        1:       b = 1'b0;
        default: b = v ? (gen_bit() ^ ($urandom_range(0, 39) == 0)) : 1'($urandom_range(0, 1));
      endcase
      step(v, b, c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
